// File: rtl/seizure_detector_if.sv
// Handshake/data bundle between the baseline/feature producers and the
// seizure detector; master drives inputs, slave is the detector.
interface seizure_detector_if #(
    parameter int data_width = 34,
    parameter int cnt_width  = 4
) ();
    logic                         en;
    logic signed [data_width-1:0] baseline;
    logic                         baseline_valid;
    logic signed [data_width-1:0] feature;
    logic                         feature_valid;
    logic                         exceed;
    logic                         data_valid;
    logic [cnt_width-1:0]         consec_cnt;
    logic                         alarm;
    logic                         alarm_start;

    modport master (
        output en, baseline, baseline_valid, feature, feature_valid,
        input  exceed, data_valid, consec_cnt, alarm, alarm_start
    );

    modport slave (
        input  en, baseline, baseline_valid, feature, feature_valid,
        output exceed, data_valid, consec_cnt, alarm, alarm_start
    );
endinterface

// File: rtl/seizure_detector.sv
// Raises an alarm after n_consec windows above thr_mult x baseline and
// holds it until hold_len consecutive quiet windows have passed.
module seizure_detector #(
    parameter int data_width = 34,
    parameter int thr_mult   = 3,
    parameter int n_consec   = 4,
    parameter int hold_len   = 8,
    parameter int cnt_width  = 4
) (
    input logic               clk,
    input logic               rst,
    seizure_detector_if.slave bus
);
    localparam int XW = data_width + 4;
    localparam logic [cnt_width-1:0] NC = cnt_width'(n_consec);
    localparam logic [cnt_width-1:0] HL = cnt_width'(hold_len);
    localparam logic [cnt_width-1:0] C1 = cnt_width'(1);

    typedef enum logic [1:0] {
        IDLE,
        MONITOR,
        CANDIDATE,
        ALARM
    } state_t;

    state_t                state;
    logic [data_width-1:0] base_reg;
    logic [cnt_width-1:0]  hold_cnt;
    logic                  baseline_seen;

    logic [XW-1:0]        thr;
    logic signed [XW-1:0] feat_x;
    logic                 exc;

    // base_reg is never negative, so thr fits XW-1 bits and its MSB is 0
    assign thr    = XW'(base_reg) * XW'(thr_mult);
    assign feat_x = {{4{bus.feature[data_width-1]}}, bus.feature};
    assign exc    = feat_x > $signed(thr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            base_reg        <= '0;
            hold_cnt        <= '0;
            baseline_seen   <= 1'b0;
            bus.exceed      <= 1'b0;
            bus.data_valid  <= 1'b0;
            bus.consec_cnt  <= '0;
            bus.alarm       <= 1'b0;
            bus.alarm_start <= 1'b0;
        end else begin
            bus.data_valid  <= 1'b0;
            bus.alarm_start <= 1'b0;
            if (!bus.en) begin
                if (baseline_seen && bus.feature_valid) begin
                    bus.data_valid <= 1'b1;
                    bus.exceed     <= exc;
                    unique case (state)
                        MONITOR: begin
                            if (exc) begin
                                bus.consec_cnt <= C1;
                                if (NC == C1) begin
                                    state           <= ALARM;
                                    bus.alarm       <= 1'b1;
                                    bus.alarm_start <= 1'b1;
                                    hold_cnt        <= HL;
                                end else begin
                                    state <= CANDIDATE;
                                end
                            end else begin
                                bus.consec_cnt <= '0;
                            end
                        end
                        CANDIDATE: begin
                            if (exc) begin
                                if (bus.consec_cnt + C1 >= NC) begin
                                    bus.consec_cnt  <= NC;
                                    state           <= ALARM;
                                    bus.alarm       <= 1'b1;
                                    bus.alarm_start <= 1'b1;
                                    hold_cnt        <= HL;
                                end else begin
                                    bus.consec_cnt <= bus.consec_cnt + C1;
                                end
                            end else begin
                                bus.consec_cnt <= '0;
                                state          <= MONITOR;
                            end
                        end
                        ALARM: begin
                            if (exc) begin
                                hold_cnt       <= HL;
                                bus.consec_cnt <= NC;
                            end else begin
                                bus.consec_cnt <= '0;
                                if (hold_cnt <= C1) begin
                                    hold_cnt  <= '0;
                                    state     <= MONITOR;
                                    bus.alarm <= 1'b0;
                                end else begin
                                    hold_cnt <= hold_cnt - C1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                // The load lands after the compare, so a coincident
                // feature still sees the previous baseline
                if (bus.baseline_valid) begin
                    base_reg      <= bus.baseline[data_width-1] ? '0
                                     : bus.baseline;
                    baseline_seen <= 1'b1;
                    if (state == IDLE) state <= MONITOR;
                end
            end
        end
    end
endmodule

// File: tb/tb_seizure_detector.sv
// Directed plus randomized bench for seizure_detector against a run-length
// reference model of the alarm rules.
module tb_seizure_detector;
    localparam int DW   = 34;
    localparam int CW   = 4;
    localparam int THR  = 3;
    localparam int NC   = 4;
    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    seizure_detector_if #(.data_width(DW), .cnt_width(CW)) bus ();

    seizure_detector #(
        .data_width(DW), .thr_mult(THR), .n_consec(NC),
        .hold_len(HOLD), .cnt_width(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    longint m_base;
    bit     m_seen;
    int     m_run;
    int     m_quiet;
    bit     m_alarm;
    bit     e_exc, e_dv, e_as;
    int     e_cnt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_base = 0; m_seen = 0; m_run = 0; m_quiet = 0; m_alarm = 0;
        e_exc = 0; e_dv = 0; e_as = 0; e_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dv"},  bus.data_valid,  e_dv);
        chk({tag, ".exc"}, bus.exceed,      e_exc);
        chk({tag, ".cnt"}, bus.consec_cnt,  e_cnt);
        chk({tag, ".al"},  bus.alarm,       m_alarm);
        chk({tag, ".as"},  bus.alarm_start, e_as);
    endtask

    // One clock: present inputs, step the model, compare after the edge.
    task automatic step(input bit en_n, input bit bv, input longint b,
                        input bit fv, input longint f, input string tag);
        bit ex;
        bus.en             = en_n;
        bus.baseline_valid = bv;
        bus.baseline       = b[DW-1:0];
        bus.feature_valid  = fv;
        bus.feature        = f[DW-1:0];
        @(posedge clk);
        #1;
        e_dv = 0;
        e_as = 0;
        if (!en_n) begin
            if (m_seen && fv) begin
                e_dv  = 1;
                ex    = f > m_base * THR;
                e_exc = ex;
                if (ex) begin
                    m_run++;
                    m_quiet = 0;
                end else begin
                    m_run = 0;
                    if (m_alarm) m_quiet++;
                end
                if (!m_alarm && m_run >= NC) begin
                    m_alarm = 1;
                    e_as    = 1;
                end else if (m_alarm && m_quiet >= HOLD) begin
                    m_alarm = 0;
                    m_quiet = 0;
                end
                if (m_alarm) e_cnt = ex ? NC : 0;
                else e_cnt = (m_run > NC) ? NC : m_run;
            end
            if (bv) begin
                m_base = (b < 0) ? 0 : b;
                m_seen = 1;
            end
        end
        check_all(tag);
    endtask

    task automatic feat(input longint f, input string tag);
        step(0, 0, 0, 1, f, tag);
    endtask

    task automatic load(input longint b, input string tag);
        step(0, 1, b, 0, 0, tag);
    endtask

    initial begin
        int en_n, bv, fv;
        longint b, f;
        model_reset();
        bus.en = 0; bus.baseline_valid = 0; bus.baseline = '0;
        bus.feature_valid = 0; bus.feature = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 0;

        feat(1000, "t1_idle");
        chk("t1_dv", bus.data_valid, 1'b0);
        feat(1000, "t1_idle2");

        load(100, "t2_load");
        feat(301, "t2_f1");
        chk("t2_cnt1", bus.consec_cnt, 4'd1);
        feat(301, "t2_f2");
        feat(301, "t2_f3");
        chk("t2_as_pre", bus.alarm_start, 1'b0);
        feat(301, "t2_f4");
        chk("t2_as", bus.alarm_start, 1'b1);
        chk("t2_alarm", bus.alarm, 1'b1);
        step(0, 0, 0, 0, 0, "t2_gap");
        chk("t2_as_once", bus.alarm_start, 1'b0);

        for (int i = 0; i < 7; i++) feat(0, "t4_q7");
        feat(400, "t4_reload");
        for (int i = 0; i < 7; i++) feat(0, "t4_q8");
        chk("t4_held", bus.alarm, 1'b1);
        feat(0, "t4_last");
        chk("t4_drop", bus.alarm, 1'b0);
        chk("t4_dv", bus.data_valid, 1'b1);

        feat(301, "t3_a");
        feat(301, "t3_b");
        feat(300, "t3_c");
        chk("t3_bound_exc", bus.exceed, 1'b0);
        chk("t3_bound_cnt", bus.consec_cnt, 4'd0);
        feat(301, "t3_d");
        chk("t3_cnt", bus.consec_cnt, 4'd1);
        feat(0, "t3_clear");

        step(0, 1, 200, 1, 350, "t5_both");
        chk("t5_old", bus.exceed, 1'b1);
        feat(350, "t5_new");
        chk("t5_new_exc", bus.exceed, 1'b0);
        load(-50, "t5_neg");
        feat(1, "t5_one");
        chk("t5_zero_thr", bus.exceed, 1'b1);
        feat(-5, "t5_negf");
        chk("t5_negf_exc", bus.exceed, 1'b0);

        load(100, "t6_load");
        for (int i = 0; i < 4; i++) feat(301, "t6_arm");
        chk("t6_alarm", bus.alarm, 1'b1);
        step(0, 0, 0, 0, 0, "t6_idle");
        #2 rst = 1;
        #1;
        model_reset();
        check_all("t6_async");
        @(posedge clk);
        #1 rst = 0;

        load(100, "t6_reload");
        feat(301, "t6_f1");
        step(1, 0, 0, 1, 301, "t6_en1");
        step(1, 1, 1000, 1, 301, "t6_en2");
        chk("t6_en_dv", bus.data_valid, 1'b0);
        chk("t6_en_cnt", bus.consec_cnt, 4'd1);
        feat(400, "t6_after");
        chk("t6_old_base", bus.exceed, 1'b1);

        for (int i = 0; i < 400; i++) begin
            en_n = ($urandom_range(0, 9) == 0);
            bv   = ($urandom_range(0, 19) == 0);
            fv   = ($urandom_range(0, 3) != 0);
            b    = longint'($urandom_range(0, 250)) - 50;
            f    = longint'($urandom_range(0, 900)) - 100;
            if ($urandom_range(0, 1) == 1) f = m_base * THR + 1;
            step(en_n[0], bv[0], b, fv[0], f, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seizure_detector.md
Name: seizure_detector

Overview:
- Sits directly downstream of the baseline stage. Consumes its scaled baseline output and the per-window feature stream, and raises a seizure alarm when the feature exceeds thr_mult × baseline for n_consec consecutive windows.
- A hold-off counter keeps the alarm asserted until hold_len consecutive windows fall below threshold.
- Output goes to the system controller.

Parameters:
- data_width, 34, signed width of baseline and feature inputs.
- thr_mult, 3, unsigned integer threshold multiplier (1..15).
- n_consec, 4, consecutive exceeding windows needed to enter alarm (1..15).
- hold_len, 8, consecutive non-exceeding windows needed to leave alarm (1..15).
- cnt_width, 4, width of the consecutive/hold counters.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- en, input, 1, active-low enable. When high, all state is frozen and valid pulses are dropped.
- baseline, input, data_width, signed baseline value.
- baseline_valid, input, 1, one-cycle pulse qualifying baseline.
- feature, input, data_width, signed feature value for the current window.
- feature_valid, input, 1, one-cycle pulse qualifying feature.
- exceed, output, 1, registered result of the latest compare: feature > threshold.
- data_valid, output, 1, one-cycle pulse, one cycle after each processed feature.
- consec_cnt, output, cnt_width, current consecutive-exceed count, saturating at n_consec.
- alarm, output, 1, level; high while in ALARM.
- alarm_start, output, 1, one-cycle pulse on entry to ALARM.

Behaviour:
- Reset (rst high, asynchronous):
  - All outputs 0; state IDLE.
  - Baseline register 0; hold counter 0; baseline_seen 0.
  - Reset mid-alarm drops alarm immediately, with no alarm_start and no data_valid.
- Baseline register:
  - Loads baseline on baseline_valid with en low; sets baseline_seen.
  - A negative baseline is stored as 0.
- Threshold arithmetic:
  - thr = baseline_reg × thr_mult, computed at width data_width+4, unsigned-extended baseline.
  - Compare: sign-extended feature > thr, strictly greater.
  - A negative feature never exceeds.
- Latency: a feature_valid at edge t updates exceed, consec_cnt, state, alarm and alarm_start at edge t+1, with data_valid=1 for exactly that cycle.
- Simultaneous baseline_valid and feature_valid: the feature is compared against the old baseline_reg; the new baseline applies from the next feature.
- State machine (transitions only on processed features unless noted):
  - IDLE: features are ignored entirely (no data_valid) until baseline_seen. On the first baseline_valid, go to MONITOR in the same edge the baseline is loaded.
  - MONITOR: exceeding feature → consec_cnt=1. If n_consec=1, go to ALARM; otherwise go to CANDIDATE. Non-exceeding feature → consec_cnt=0.
  - CANDIDATE:
    - Exceeding feature → consec_cnt+1; when it reaches n_consec, go to ALARM, pulse alarm_start, and load hold counter = hold_len.
    - Non-exceeding feature → consec_cnt=0, back to MONITOR.
  - ALARM:
    - Exceeding feature → reload hold counter = hold_len; consec_cnt stays saturated at n_consec.
    - Non-exceeding feature → consec_cnt=0 and hold counter −1. When it reaches 0, go to MONITOR and drop alarm on the same edge as that feature's data_valid.
- Baseline updates in any non-IDLE state do not change state or counters.
- en high:
  - Registers hold value; pulses presented while en is high are lost.
  - data_valid and alarm_start are forced 0 for those cycles.
  - alarm level holds.
- Counters never wrap: consec_cnt saturates at n_consec; the hold counter floors at 0.

Test Plan:
1. Reset, then feature_valid with feature=1000 before any baseline → no data_valid, alarm=0, state IDLE.
2. baseline=100 (thr=300); features 301,301,301,301 → exceed=1 each; consec_cnt 1,2,3,4; alarm_start pulses one cycle after the 4th feature, and alarm=1.
3. baseline=100; features 301,301,300,301 → exceed 1,1,0,1; consec_cnt 1,2,0,1; alarm stays 0 (boundary value 300 does not exceed).
4. In ALARM, 7 features of 0 then 1 feature of 400 then 8 features of 0 → alarm held through the reload; it deasserts together with data_valid of the 8th trailing 0.
5. baseline_valid (200) and feature_valid (350) on the same edge, old baseline 100 → exceed=1. Next feature 350 → exceed=0 (thr=600). baseline=-50 → thr=0, so feature=1 exceeds.
6. Assert rst asynchronously mid-ALARM (between edges) → alarm, consec_cnt, exceed drop immediately. With en high, feature pulses produce no data_valid and counters hold.
